btb_predictor: RTL

//   Direct-mapped branch target buffer with 2-bit saturating direction counters.

---
 rtl/btb_predictor.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/btb_predictor.sv
// ---------------------------------------------------------------------------
// btb_predictor
//   Direct-mapped branch target buffer with 2-bit saturating direction
//   counters. The fetch stage looks up PCF combinationally and gets a
//   taken/not-taken guess plus a target. Conditional branches resolved in
//   EX train the table one edge later. A small sweep controller invalidates
//   every entry after reset and whenever BtbClear is raised. The block also
//   counts mispredicted EX branches.
//
// Ports
//   clk                     in   1   clock, all state updates on rising edge
//   rst                     in   1   synchronous active-high reset
//   PCF                     in   32  fetch PC used for lookup
//   BranchPredictedF        out  1   predict taken for PCF
//   BranchPredictedTargetF  out  32  predicted target for PCF (0 on miss)
//   BranchInstE             in   1   EX holds a conditional branch
//   PCE                     in   32  PC of the EX instruction
//   BranchE                 in   1   EX branch resolved taken
//   BranchTarget            in   32  resolved target of the EX branch
//   BranchPredictedE        in   1   prediction made earlier for that branch
//   BtbClear                in   1   request full invalidation
//   BtbReady                out  1   table usable (no sweep in progress)
//   MispredictCount         out  32  mispredicted EX branch count (wraps)
// ---------------------------------------------------------------------------
module btb_predictor #(
   parameter int ENTRIES = 64,
   parameter int IDX_W   = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   output logic        BranchPredictedF,
   output logic [31:0] BranchPredictedTargetF,
   input  logic        BranchInstE,
   input  logic [31:0] PCE,
   input  logic        BranchE,
   input  logic [31:0] BranchTarget,
   input  logic        BranchPredictedE,
   input  logic        BtbClear,
   output logic        BtbReady,
   output logic [31:0] MispredictCount
);

   localparam int TAG_W = 32 - IDX_W - 2;

   localparam logic [0:0] ST_SWEEP = 1'b0;
   localparam logic [0:0] ST_IDLE  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [IDX_W-1:0] sidx_q, sidx_d;
   logic [31:0]      mispredict_count_q, mispredict_count_d;

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];
   logic [31:0]        target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];

   logic [IDX_W-1:0] idx_f, idx_e;
   logic [TAG_W-1:0] tag_f, tag_e;
   logic             hit_f, hit_e;
   logic             upd;
   logic             mispredict;
   logic             unused_pc_low;

   assign idx_f = PCF[IDX_W+1:2];
   assign tag_f = PCF[31:IDX_W+2];
   assign idx_e = PCE[IDX_W+1:2];
   assign tag_e = PCE[31:IDX_W+2];

   // Instructions are word aligned, so the two low PC bits never matter.
   assign unused_pc_low = &{1'b0, PCF[1:0], PCE[1:0]};

   assign BtbReady = (state_q == ST_IDLE);

   // Fetch lookup sees only pre-edge contents; an EX update in the same
   // cycle becomes visible one cycle later. Everything is masked while a
   // sweep runs because half-cleared entries must not be trusted.
   always_comb begin
      hit_f                  = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
      BranchPredictedF       = BtbReady && hit_f && ctr_q[idx_f][1];
      BranchPredictedTargetF = (BtbReady && hit_f) ? target_q[idx_f] : 32'h0;
   end

   // Sweep controller: walks every index once, clearing valid bits. A
   // BtbClear while sweeping restarts from index 0 so the full table is
   // guaranteed clean after the last request.
   always_comb begin
      state_d = state_q;
      sidx_d  = sidx_q;
      case (state_q)
         ST_SWEEP: begin
            if (BtbClear) begin
               sidx_d = '0;
            end else begin
               sidx_d = sidx_q + 1'b1;
               if (sidx_q == IDX_W'(ENTRIES - 1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            if (BtbClear) begin
               state_d = ST_SWEEP;
               sidx_d  = '0;
            end
         end
      endcase
   end

   // Training. A clear in the same cycle wins over the update, and nothing
   // is trained while the table is being swept or reset.
   always_comb begin
      hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
      upd      = BranchInstE && BtbReady && !BtbClear && !rst;
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (state_q == ST_SWEEP) begin
         valid_d[sidx_q] = 1'b0;
      end
      if (upd) begin
         if (hit_e) begin
            if (BranchE) begin
               if (ctr_q[idx_e] != 2'b11) begin
                  ctr_d[idx_e] = ctr_q[idx_e] + 2'd1;
               end
               target_d[idx_e] = BranchTarget;
            end else if (ctr_q[idx_e] != 2'b00) begin
               ctr_d[idx_e] = ctr_q[idx_e] - 2'd1;
            end
         end else if (BranchE) begin
            // Allocate weakly-taken so one contrary outcome flips the guess.
            valid_d[idx_e]  = 1'b1;
            tag_d[idx_e]    = tag_e;
            target_d[idx_e] = BranchTarget;
            ctr_d[idx_e]    = 2'b10;
         end
      end
   end

   // Mispredictions are counted even when a clear drops the table update.
   always_comb begin
      mispredict         = BranchInstE && BtbReady && (BranchE != BranchPredictedE);
      mispredict_count_d = mispredict_count_q + {31'b0, mispredict};
   end

   assign MispredictCount = mispredict_count_q;

   // Controller and counter state; reset puts the controller into a fresh sweep.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= ST_SWEEP;
         sidx_q             <= '0;
         mispredict_count_q <= '0;
      end else begin
         state_q            <= state_d;
         sidx_q             <= sidx_d;
         mispredict_count_q <= mispredict_count_d;
      end
   end

   // Table storage has no reset; the sweep is what invalidates it.
   always_ff @(posedge clk) begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
   end

endmodule
